float_mul_serial: RTL and testbench

FLOAT_MUL_SERIAL -- requirements
Module: float_mul_serial

---
 rtl/float_mul_serial.sv | 121 ++++++++++++
 tb/tb_float_mul_serial.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/float_mul_serial.sv
// Serial IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product,
// one normalisation cycle, fixed 26-cycle latency, valid/ready handshake on both sides.
module float_mul_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_udf;

  logic        r_sign_p0;
  logic [7:0]  r_ea_p0;
  logic [7:0]  r_eb_p0;
  logic [47:0] r_ma_sh_p0;
  logic [23:0] r_mb_p0;
  logic [47:0] r_acc_p0;
  logic [4:0]  r_cnt_p0;

  logic [31:0] r_res_p1;
  logic        r_ovf_p1;
  logic        r_udf_p1;
  logic        r_pend_p1;

  // Normalise, truncate and classify; returns {overflow, underflow, result}.
  function automatic logic [33:0] norm_pack(input logic sign, input logic [7:0] ea,
                                            input logic [7:0] eb, input logic [47:0] p);
    logic signed [9:0] e;
    logic [22:0]       m;
    e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'sd1;
    end else begin
      m = p[45:23];
    end
    if (ea == 8'd0 || eb == 8'd0)
      norm_pack = {2'b00, 32'h0000_0000};
    else if (ea == 8'hFF || eb == 8'hFF || e >= 10'sd255)
      norm_pack = {2'b10, sign, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      norm_pack = {2'b01, 32'h0000_0000};
    else
      norm_pack = {2'b00, sign, e[7:0], m};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 32'h0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_acc_p0    <= 48'h0;
      r_cnt_p0    <= 5'd0;
      r_pend_p1   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign_p0  <= a[31] ^ b[31];
          r_ea_p0    <= a[30:23];
          r_eb_p0    <= b[30:23];
          r_ma_sh_p0 <= {24'd0, 1'b1, a[22:0]};
          r_mb_p0    <= {1'b1, b[22:0]};
          r_acc_p0   <= 48'h0;
          r_cnt_p0   <= 5'd0;
          r_in_ready <= 1'b0;
          r_state    <= MUL;
        end
        // stage p0: one multiplier bit per cycle, LSB first
        MUL: begin
          if (r_mb_p0[0]) r_acc_p0 <= r_acc_p0 + r_ma_sh_p0;
          r_ma_sh_p0 <= r_ma_sh_p0 << 1;
          r_mb_p0    <= r_mb_p0 >> 1;
          r_cnt_p0   <= r_cnt_p0 + 5'd1;
          if (r_cnt_p0 == 5'd23) r_state <= NORM;
        end
        // stage p1: normalised result held one cycle before it is presented
        NORM: begin
          {r_ovf_p1, r_udf_p1, r_res_p1} <= norm_pack(r_sign_p0, r_ea_p0, r_eb_p0, r_acc_p0);
          r_pend_p1 <= 1'b1;
          r_state   <= DONE;
        end
        DONE: if (r_pend_p1) begin
          r_pend_p1   <= 1'b0;
          r_out_valid <= 1'b1;
          r_result    <= r_res_p1;
          r_ovf       <= r_ovf_p1;
          r_udf       <= r_udf_p1;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_float_mul_serial.sv
// Self-checking bench for float_mul_serial: directed vectors with literal expectations
// plus randomized operands/backpressure checked every cycle against an arithmetic model.
module tb_float_mul_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  float_mul_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        un;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   rand_done = 1'b0;

  // Reference: exact 48-bit product of the significands, then the IEEE-style rules.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [22:0] m;
    int          ex, ey, e;
    logic        s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    p  = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e  = ex + ey - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else m = p[45:23];
    if (ex == 0 || ey == 0)                return {2'b00, 32'h0};
    if (ex == 255 || ey == 255 || e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e <= 0)                            return {2'b01, 32'h0};
    return {2'b00, s, e[7:0], m};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Compare process: outputs sampled at the falling edge against the pending-op queue.
  always @(negedge clk) begin
    logic exp_ov;
    logic [33:0] mv;
    exp_t e;
    if (mon_en) begin
      exp_ov = (q.size() != 0) && (cyc >= q[0].acc + 26);
      chk("mon_out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("mon_in_ready", {31'd0, in_ready}, {31'd0, q.size() == 0});
      if (out_valid && exp_ov) begin
        chk("mon_result", result, q[0].res);
        chk("mon_flags", {30'd0, overflow, underflow}, {30'd0, q[0].ov, q[0].un});
      end
      if (rst) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && in_ready) begin
          mv = model(a, b);
          e.res = mv[31:0]; e.ov = mv[33]; e.un = mv[32]; e.acc = cyc + 1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #2; n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout: in_ready=%0b expected 1", in_ready);
    end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_out(output logic [31:0] r, output logic [1:0] f);
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #2; n++; end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL wait_out_timeout: out_valid=%0b expected 1", out_valid);
    end
    r = result; f = {overflow, underflow};
  endtask

  task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic [1:0] ef);
    logic [31:0] r;
    logic [1:0]  f;
    issue(x, y);
    wait_out(r, f);
    chk(name, r, er);
    chk({name, "_flags"}, {30'd0, f}, {30'd0, ef});
    @(posedge clk); #2;
  endtask

  initial begin
    logic [31:0] r, held;
    logic [1:0]  f;
    rst = 1'b1; in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
    @(posedge clk); #2;
    mon_en = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    directed("two_x_three", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 2'b00);
    directed("norm_p47",    32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, 2'b00);
    directed("zero_op",     32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 2'b00);
    directed("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 2'b10);
    directed("underflow",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 2'b01);
    directed("inf_in",      32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 2'b10);

    // Backpressure: result must hold, in_valid pulses must be ignored.
    out_ready = 1'b0;
    issue(32'h4040_0000, 32'h4040_0000);
    wait_out(held, f);
    chk("hold_first", held, 32'h4110_0000);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = $urandom; b = $urandom;
      @(posedge clk); #2;
      chk("hold_result", result, held);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    directed("back_to_back", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 2'b00);

    // Reset in the middle of MUL abandons the operation.
    issue(32'h4000_0000, 32'h4000_0000);
    repeat (9) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (30) begin @(posedge clk); #2; end
    directed("after_rst", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 2'b00);

    // Randomized operands with random backpressure.
    fork
      while (!rand_done) begin
        @(posedge clk); #2;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(90, 165));
      if ($urandom_range(0, 3) != 0) y[30:23] = 8'($urandom_range(90, 165));
      issue(x, y);
    end
    rand_done = 1'b1;
    repeat (2) @(posedge clk);
    #3 out_ready = 1'b1;
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
